// File: rtl/cpu_defs.sv
// cpu_defs: shared fetch-stage state encoding, error codes and constant words
package cpu_defs;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_ERR} state_t;
  localparam logic [1:0]  ERR_NONE     = 2'b00;
  localparam logic [1:0]  ERR_MISALIGN = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT  = 2'b10;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [31:0] BASE_ADDR    = 32'h0000_3000;
endpackage

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage with imem handshake, IR hand-off, redirect and error handling
module if_fetch
  import cpu_defs::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] NOP_WORD = cpu_defs::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pcwr,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        id_ready,
  output logic        fetch_err,
  output logic [1:0]  err_code
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] pend_q, pend_d, ir_q, ir_d, ir_pc_q, ir_pc_d;
  logic ir_valid_q, ir_valid_d, first_q, first_d, aligned, flush, timed_out;
  logic [1:0] err_q, err_d;
  assign aligned   = pc[1:0] == 2'b00;
  assign flush     = redirect && state_q inside {S_REQ, S_WAIT, S_HOLD, S_DRAIN};
  assign cnt_inc   = (cnt_q == CMAX) ? cnt_q : cnt_q + 1'b1;
  assign timed_out = cnt_inc == CMAX;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    err_d      = err_q;
    first_d    = 1'b0;
    imem_req   = 1'b0;
    pcwr       = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // a redirect withdraws the request unless it is being granted this very cycle
        imem_req = aligned && (imem_gnt || !redirect);
        if (imem_req && imem_gnt) begin
          pend_d  = pc;
          cnt_d   = '0;
          state_d = redirect ? S_DRAIN : S_WAIT;
        end else if (!aligned && !redirect) begin
          state_d = S_ERR;
          err_d   = ERR_MISALIGN;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (imem_rvalid && !redirect) begin
          ir_d       = imem_rdata;
          ir_pc_d    = pend_q;
          ir_valid_d = 1'b1;
          first_d    = 1'b1;
          state_d    = S_HOLD;
        end else if (imem_rvalid) begin
          state_d = S_REQ;
        end else if (redirect) begin
          state_d = S_DRAIN;
        end else if (timed_out) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      S_HOLD: begin
        pcwr = first_q;
        if (ir_valid_q && id_ready) begin
          ir_valid_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_inc;
        if (imem_rvalid) begin
          state_d = S_REQ;
        end else if (timed_out) begin
          state_d = S_ERR;
          err_d   = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
    if (flush) begin
      pcwr       = 1'b1;
      ir_valid_d = 1'b0;
      ir_d       = NOP_WORD;
      if (state_q == S_HOLD) state_d = S_REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      ir_q       <= NOP_WORD;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      first_q    <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      first_q    <= first_d;
      err_q      <= err_d;
    end
  end
  assign imem_addr = imem_req ? pc : '0;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = state_q == S_ERR;
  assign err_code  = err_q;
endmodule
